blake2s_block_sched: RTL and testbench

//  Sequences the BLAKE2s core: takes the byte stream (key bytes, then message bytes) from io_intf
//  and feeds it to blake2s_hash256 as 64-byte blocks.
//  - Generates data_idx, block_first and block_last.
//  - Inserts the zero padding for the key block and the final block.
//  - Emits the all-zero block for an empty unkeyed message.
//  - Holds the stream off while the core is busy and checks the stream length against kk+ll.

---
 rtl/blake2s_pkg.sv | 30 +++
 rtl/blake2s_sched_wdog.sv | 35 +++
 rtl/blake2s_block_sched.sv | 232 +++++++++++++++++++++++
 tb/tb_blake2s_block_sched.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2s_pkg.sv
// Shared types and constants for the BLAKE2s block scheduler.
package blake2s_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned KK_MAX      = 32;
    localparam int unsigned NN_MAX      = 32;
    localparam logic [5:0]  LAST_IDX    = 6'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BWAIT,
        ST_KEY,
        ST_KPAD,
        ST_MSG,
        ST_MPAD,
        ST_ZERO,
        ST_DONE
    } sched_state_e;

    typedef struct packed {
        logic [5:0]  kk;
        logic [5:0]  nn;
        logic [63:0] ll;
    } sched_cfg_t;

    function automatic logic cfg_valid(input logic [5:0] kk, input logic [5:0] nn);
        return (32'(kk) <= KK_MAX) && (nn != 6'd0) && (32'(nn) <= NN_MAX);
    endfunction

endpackage

// File: rtl/blake2s_sched_wdog.sv
// Idle-input watchdog for the block scheduler; only instantiated when
// BLAKE2S_SCHED_WDOG_EN is defined. Fires on the 2**WDOG_W-th consecutive idle cycle.
module blake2s_sched_wdog #(
    parameter int WDOG_W = 16
) (
    input  logic clk,
    input  logic nreset,
    input  logic en_i,
    input  logic kick_i,
    output logic expire_o
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    assign expire_o = en_i && !kick_i && (cnt_q == {WDOG_W{1'b1}});

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || kick_i || expire_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/blake2s_block_sched.sv
// Cuts the key+message byte stream into padded 64-byte blocks for the BLAKE2s core.
// Optional idle watchdog enabled by defining BLAKE2S_SCHED_WDOG_EN.
module blake2s_block_sched
    import blake2s_pkg::*;
`ifdef BLAKE2S_SCHED_WDOG_EN
#(
    parameter int WDOG_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        cfg_v_i,
    input  logic [5:0]  kk_i,
    input  logic [5:0]  nn_i,
    input  logic [63:0] ll_i,
    input  logic        in_v_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_last_i,
    output logic        in_ready_o,
    input  logic        core_ready_i,
    output logic        data_v_o,
    output logic [7:0]  data_o,
    output logic [5:0]  data_idx_o,
    output logic        block_first_o,
    output logic        block_last_o,
    output logic [5:0]  kk_o,
    output logic [5:0]  nn_o,
    output logic [63:0] ll_o,
    output logic        busy_o,
    output logic        err_o
);

    sched_state_e state_q, state_d;
    sched_cfg_t   cfg_q, cfg_d;
    logic [63:0]  rem_q, rem_d;
    logic [5:0]   idx_q, idx_d;
    logic         sent_q, sent_d;
    logic         err_q, err_d;
    logic         data_v_q, data_v_d;
    logic [7:0]   data_q, data_d;
    logic [5:0]   data_idx_q, data_idx_d;
    logic         first_q, first_d;
    logic         last_q, last_d;
    logic         in_ready_q, in_ready_d;
    logic         busy_q, busy_d;

    logic accept;
    logic key_done;
    logic final_byte;
    logic stream_err;
    logic wdog_expire;

`ifdef BLAKE2S_SCHED_WDOG_EN
    blake2s_sched_wdog #(
        .WDOG_W(WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .nreset  (nreset),
        .en_i    (in_ready_q),
        .kick_i  (in_v_i),
        .expire_o(wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        sent_d     = sent_q;
        err_d      = err_q;
        data_v_d   = 1'b0;
        data_d     = 8'd0;
        data_idx_d = data_idx_q;
        first_d    = first_q;
        last_d     = last_q;

        accept   = in_v_i && in_ready_q;
        key_done = (idx_q == cfg_q.kk - 6'd1);
        // The byte numbered kk+ll is either the last key byte (ll==0) or the last message byte.
        final_byte = (state_q == ST_KEY) ? (key_done && (cfg_q.ll == 64'd0))
                                         : (rem_q == 64'd1);
        stream_err = accept && (in_last_i != final_byte);

        case (state_q)
            ST_IDLE: begin
                if (cfg_v_i) begin
                    if (cfg_valid(kk_i, nn_i)) begin
                        cfg_d   = '{kk: kk_i, nn: nn_i, ll: ll_i};
                        rem_d   = ll_i;
                        sent_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = ST_BWAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BWAIT: begin
                if (core_ready_i) begin
                    idx_d  = 6'd0;
                    sent_d = 1'b1;
                    if ((cfg_q.kk != 6'd0) && !sent_q) begin
                        state_d = ST_KEY;
                        first_d = 1'b1;
                        last_d  = (cfg_q.ll == 64'd0);
                    end else if (rem_q == 64'd0) begin
                        state_d = ST_ZERO;
                        first_d = 1'b1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = ST_MSG;
                        first_d = !sent_q;
                        last_d  = (rem_q <= 64'(BLOCK_BYTES));
                    end
                end
            end
            ST_KEY: begin
                if (accept) begin
                    data_v_d   = 1'b1;
                    data_d     = in_data_i;
                    data_idx_d = idx_q;
                    idx_d      = idx_q + 6'd1;
                    if (key_done) begin
                        state_d = ST_KPAD;
                    end
                end
            end
            ST_KPAD: begin
                data_v_d   = 1'b1;
                data_idx_d = idx_q;
                idx_d      = idx_q + 6'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = (cfg_q.ll == 64'd0) ? ST_DONE : ST_BWAIT;
                end
            end
            ST_MSG: begin
                if (accept) begin
                    data_v_d   = 1'b1;
                    data_d     = in_data_i;
                    data_idx_d = idx_q;
                    idx_d      = idx_q + 6'd1;
                    if (rem_q != 64'd0) begin
                        rem_d = rem_q - 64'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = (rem_q == 64'd1) ? ST_DONE : ST_BWAIT;
                    end else if (rem_q == 64'd1) begin
                        state_d = ST_MPAD;
                    end
                end
            end
            ST_MPAD, ST_ZERO: begin
                data_v_d   = 1'b1;
                data_idx_d = idx_q;
                idx_d      = idx_q + 6'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                first_d = 1'b0;
                last_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A bad stream or a stalled source drops the hash without emitting the offending byte.
        if (stream_err || wdog_expire) begin
            state_d  = ST_IDLE;
            err_d    = 1'b1;
            data_v_d = 1'b0;
            data_d   = 8'd0;
            first_d  = 1'b0;
            last_d   = 1'b0;
        end

        in_ready_d = (state_d == ST_KEY) || (state_d == ST_MSG);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            rem_q      <= 64'd0;
            idx_q      <= 6'd0;
            sent_q     <= 1'b0;
            err_q      <= 1'b0;
            data_v_q   <= 1'b0;
            data_q     <= 8'd0;
            data_idx_q <= 6'd0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            sent_q     <= sent_d;
            err_q      <= err_d;
            data_v_q   <= data_v_d;
            data_q     <= data_d;
            data_idx_q <= data_idx_d;
            first_q    <= first_d;
            last_q     <= last_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign data_v_o      = data_v_q;
    assign data_o        = data_q;
    assign data_idx_o    = data_idx_q;
    assign block_first_o = first_q;
    assign block_last_o  = last_q;
    assign kk_o          = cfg_q.kk;
    assign nn_o          = cfg_q.nn;
    assign ll_o          = cfg_q.ll;
    assign busy_o        = busy_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_blake2s_block_sched.sv
// Self-checking bench for blake2s_block_sched: block streams are compared against a
// queue-based model that pads key and message into 64-byte blocks.
module tb_blake2s_block_sched;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cfg_v_i;
    logic [5:0]  kk_i;
    logic [5:0]  nn_i;
    logic [63:0] ll_i;
    logic        in_v_i;
    logic [7:0]  in_data_i;
    logic        in_last_i;
    logic        in_ready_o;
    logic        core_ready_i;
    logic        data_v_o;
    logic [7:0]  data_o;
    logic [5:0]  data_idx_o;
    logic        block_first_o;
    logic        block_last_o;
    logic [5:0]  kk_o;
    logic [5:0]  nn_o;
    logic [63:0] ll_o;
    logic        busy_o;
    logic        err_o;

    typedef struct packed {
        logic [7:0] d;
        logic [5:0] idx;
        logic       f;
        logic       l;
    } ent_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   stall_left = 0;
    bit   stall_arm = 1'b0;
    int   ready_cycles = 0;
    ent_t cap_q[$];

    logic [95:0] outs;
    assign outs = {in_ready_o, data_v_o, data_o, data_idx_o, block_first_o, block_last_o,
                   kk_o, nn_o, ll_o, busy_o, err_o};

`ifdef BLAKE2S_SCHED_WDOG_EN
    blake2s_block_sched #(.WDOG_W(4)) dut (
`else
    blake2s_block_sched dut (
`endif
        .clk          (clk),
        .nreset       (nreset),
        .cfg_v_i      (cfg_v_i),
        .kk_i         (kk_i),
        .nn_i         (nn_i),
        .ll_i         (ll_i),
        .in_v_i       (in_v_i),
        .in_data_i    (in_data_i),
        .in_last_i    (in_last_i),
        .in_ready_o   (in_ready_o),
        .core_ready_i (core_ready_i),
        .data_v_o     (data_v_o),
        .data_o       (data_o),
        .data_idx_o   (data_idx_o),
        .block_first_o(block_first_o),
        .block_last_o (block_last_o),
        .kk_o         (kk_o),
        .nn_o         (nn_o),
        .ll_o         (ll_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    // Output capture and core back-pressure window, sampled mid-cycle.
    always @(negedge clk) begin
        if (stall_left > 0) begin
            n_cmp++;
            if (data_v_o !== 1'b0 || in_ready_o !== 1'b0) begin
                n_bad++;
                $display("FAIL core_stall: data_v=%b in_ready=%b required 0 0", data_v_o, in_ready_o);
            end
            stall_left--;
            if (stall_left == 0) core_ready_i = 1'b1;
        end
        if (in_ready_o === 1'b1) ready_cycles++;
        if (data_v_o === 1'b1) begin
            cap_q.push_back(ent_t'{d: data_o, idx: data_idx_o, f: block_first_o, l: block_last_o});
            if (stall_arm && data_idx_o == 6'd63) begin
                stall_arm    = 1'b0;
                stall_left   = 10;
                core_ready_i = 1'b0;
            end
        end
    end

    task automatic do_cfg(input int kk, input int nn, input int ll);
        cfg_v_i = 1'b1;
        kk_i    = 6'(kk);
        nn_i    = 6'(nn);
        ll_i    = 64'(ll);
        @(posedge clk); #1;
        cfg_v_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int cyc = 0;
        bit acc = 1'b0;
        while (!acc && cyc < 50) begin
            in_v_i    = 1'b1;
            in_data_i = d;
            in_last_i = last;
            @(negedge clk);
            acc = in_v_i && in_ready_o;
            @(posedge clk); #1;
            cyc++;
        end
        in_v_i    = 1'b0;
        in_last_i = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL send_byte: byte %h not accepted within %0d cycles", d, cyc);
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (busy_o === 1'b1 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_timeout: busy_o=%b required 0", name, busy_o);
        end
    endtask

    // Runs one hash with random input gaps and compares every issued byte with the model.
    task automatic run_hash(input int kk, input int ll, input bit stall, input bit directed,
                            input string name);
        logic [7:0] src[$];
        logic [7:0] strm[$];
        ent_t       exp_q[$];
        int         n = kk + ll;
        int         nblk;
        int         i = 0;
        int         cyc = 0;
        bit         acc;

        for (int j = 0; j < n; j++) src.push_back(directed ? 8'(8'h61 + j) : 8'($urandom));
        for (int j = 0; j < kk; j++) strm.push_back(src[j]);
        if (kk > 0) while (strm.size() % 64 != 0) strm.push_back(8'h00);
        for (int j = kk; j < n; j++) strm.push_back(src[j]);
        while (strm.size() % 64 != 0) strm.push_back(8'h00);
        if (strm.size() == 0) repeat (64) strm.push_back(8'h00);
        nblk = strm.size() / 64;
        foreach (strm[j])
            exp_q.push_back(ent_t'{d: strm[j], idx: 6'(j % 64), f: (j / 64 == 0), l: (j / 64 == nblk - 1)});

        cap_q.delete();
        ready_cycles = 0;
        do_cfg(kk, 32, ll);
        stall_arm = stall;
        n_cmp++;
        if ({kk_o, nn_o, ll_o} !== {6'(kk), 6'd32, 64'(ll)}) begin
            n_bad++;
            $display("FAIL %s cfg_out: got %h/%h/%h required %h/20/%h", name, kk_o, nn_o, ll_o, kk, ll);
        end

        while ((i < n || busy_o === 1'b1) && cyc < 4000) begin
            in_v_i    = (i < n) && ($urandom_range(0, 3) != 0);
            in_data_i = (i < n) ? src[i] : 8'h00;
            in_last_i = in_v_i && (i == n - 1);
            @(negedge clk);
            acc = in_v_i && in_ready_o;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        in_v_i    = 1'b0;
        in_last_i = 1'b0;

        n_cmp++;
        if (cyc >= 4000) begin
            n_bad++;
            $display("FAIL %s timeout: accepted %0d of %0d bytes, busy_o=%b", name, i, n, busy_o);
        end
        n_cmp++;
        if (cap_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL %s byte_count: got %0d required %0d", name, cap_q.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < cap_q.size(); j++) begin
            n_cmp++;
            if (cap_q[j] !== exp_q[j]) begin
                n_bad++;
                $display("FAIL %s byte %0d: got d=%h idx=%0d f=%b l=%b required d=%h idx=%0d f=%b l=%b",
                         name, j, cap_q[j].d, cap_q[j].idx, cap_q[j].f, cap_q[j].l,
                         exp_q[j].d, exp_q[j].idx, exp_q[j].f, exp_q[j].l);
                break;
            end
        end
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL %s err: got %b required 0", name, err_o);
        end
        if (n == 0) begin
            n_cmp++;
            if (ready_cycles != 0) begin
                n_bad++;
                $display("FAIL %s in_ready: high for %0d cycles required 0", name, ready_cycles);
            end
        end
        if (stall) begin
            n_cmp++;
            if (stall_arm !== 1'b0 || stall_left != 0) begin
                n_bad++;
                $display("FAIL %s stall_window: arm=%b left=%0d required 0 0", name, stall_arm, stall_left);
            end
        end
        $display("hash %s kk=%0d ll=%0d: %0d bytes out, %0d expected", name, kk, ll, cap_q.size(), exp_q.size());
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (outs !== 96'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        nreset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (outs !== 96'd0) begin
            n_bad++;
            $display("FAIL post_reset_outputs: got %h required 0", outs);
        end
    endtask

    task automatic test_single_block();
        run_hash(0, 3, 1'b0, 1'b1, "single_block");
    endtask

    task automatic test_zero_block();
        run_hash(0, 0, 1'b0, 1'b0, "zero_block");
    endtask

    task automatic test_keyed();
        run_hash(32, 64, 1'b0, 1'b0, "keyed");
        run_hash(17, 0, 1'b0, 1'b0, "key_only");
    endtask

    task automatic test_core_stall();
        run_hash(0, 65, 1'b1, 1'b0, "core_stall");
    endtask

    task automatic test_random();
        repeat (4) run_hash(int'($urandom_range(0, 32)), int'($urandom_range(0, 200)), 1'b0, 1'b0, "random");
    endtask

    task automatic test_stream_error();
        cap_q.delete();
        do_cfg(0, 32, 3);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        n_cmp++;
        if ({err_o, busy_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL early_last: err/busy got %b%b required 10", err_o, busy_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (cap_q.size() != 1) begin
            n_bad++;
            $display("FAIL early_last_bytes: got %0d required 1", cap_q.size());
        end

        do_cfg(0, 32, 2);
        n_cmp++;
        if ({err_o, busy_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL err_clear: err/busy got %b%b required 01", err_o, busy_o);
        end
        cap_q.delete();
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        n_cmp++;
        if ({err_o, busy_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL missing_last: err/busy got %b%b required 10", err_o, busy_o);
        end
        n_cmp++;
        if (cap_q.size() != 1) begin
            n_bad++;
            $display("FAIL missing_last_bytes: got %0d required 1", cap_q.size());
        end

        do_cfg(0, 32, 0);
        wait_idle("err_clear2");
        n_cmp++;
        if (err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear2: got %b required 0", err_o);
        end
        do_cfg(40, 32, 5);
        n_cmp++;
        if ({err_o, busy_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL bad_kk: err/busy got %b%b required 10", err_o, busy_o);
        end
        do_cfg(0, 32, 0);
        wait_idle("err_clear3");
        do_cfg(4, 0, 5);
        n_cmp++;
        if ({err_o, busy_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL bad_nn: err/busy got %b%b required 10", err_o, busy_o);
        end
        $display("stream error checks done");
    endtask

`ifdef BLAKE2S_SCHED_WDOG_EN
    task automatic test_watchdog();
        do_cfg(0, 32, 10);
        send_byte(8'haa, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        n_cmp++;
        if ({err_o, busy_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL wdog_early: err/busy got %b%b required 01", err_o, busy_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({err_o, busy_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL wdog_fire: err/busy got %b%b required 10", err_o, busy_o);
        end
        $display("watchdog check done");
    endtask
`endif

    task automatic test_reset_mid_hash();
        do_cfg(0, 32, 100);
        repeat (20) begin
            in_v_i    = 1'b1;
            in_data_i = 8'($urandom_range(1, 255));
            in_last_i = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (data_v_o !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_data_v: got %b required 1", data_v_o);
        end
        #2;
        nreset = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 96'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h required 0", outs);
        end
        in_v_i = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (outs !== 96'd0) begin
            n_bad++;
            $display("FAIL after_reset_release: got %h required 0", outs);
        end
        $display("mid-hash reset check done");
    endtask

    initial begin
        nreset       = 1'b0;
        cfg_v_i      = 1'b0;
        kk_i         = 6'd0;
        nn_i         = 6'd0;
        ll_i         = 64'd0;
        in_v_i       = 1'b0;
        in_data_i    = 8'd0;
        in_last_i    = 1'b0;
        core_ready_i = 1'b1;

        test_reset();
        test_single_block();
        test_zero_block();
        test_keyed();
        test_core_stall();
        test_random();
        test_stream_error();
`ifdef BLAKE2S_SCHED_WDOG_EN
        test_watchdog();
`endif
        test_reset_mid_hash();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
